// File: rtl/sha256_padder_pkg.sv
// Shared constants, state encoding and last-word masking for the SHA-256 padder.
//   BLOCK_W      width of one emitted message block
//   WORD_W       width of one input message word
//   LEN_FIELD_W  width of the trailing big-endian bit-length field
//   PAD_WORD     word carrying the lone 0x80 terminator byte
package sha256_padder_pkg;

    localparam int unsigned BLOCK_W     = 512;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned LEN_FIELD_W = 64;

    localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Keep the first nbytes bytes of the final word and place 0x80 right after them.
    // A full final word (4..7) is returned untouched; its 0x80 goes into the next word.
    function automatic logic [WORD_W-1:0] last_word_mask(input logic [WORD_W-1:0] data,
                                                         input logic [2:0]        nbytes);
        logic [WORD_W-1:0] w;
        case (nbytes)
            3'd0:    w = PAD_WORD;
            3'd1:    w = {data[31:24], 8'h80, 16'h0000};
            3'd2:    w = {data[31:16], 8'h80, 8'h00};
            3'd3:    w = {data[31:8], 8'h80};
            default: w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit big-endian message words into 512-bit blocks,
// appends the 0x80 terminator, zero fill and the 64-bit message bit-length, and hands
// blocks to the hash core one at a time, tagged first/final.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   in_valid/in_ready/in_data         message word stream (byte 0 in [31:24])
//   in_last/in_bytes                  final word marker and its valid byte count (0..4)
//   blk_valid/blk_ready/blk_data      block handshake and payload (word 0 in [511:480])
//   blk_first/blk_final               block opens / closes its message
//   busy                              padder holds an open message or pending block
module sha256_padder
    import sha256_padder_pkg::*;
#(
    parameter int unsigned LEN_W = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_last,
    input  logic [2:0]         in_bytes,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic [BLOCK_W-1:0] blk_data,
    output logic               blk_first,
    output logic               blk_final,
    output logic               busy
);

    state_t               state_q;
    logic [3:0]           idx_q;
    logic [LEN_W-1:0]     len_q;
    logic                 pend80_q;   // terminator still owed to the next word
    logic                 first_q;    // next emitted block opens a message
    logic                 msg_end_q;  // last word taken, padding not yet complete
    logic                 len_hi_q;   // upper length word already written at idx 14
    logic [BLOCK_W-1:0]   buf_q;

    logic [4:0]             idx_inc;
    logic [8:0]             wr_base;
    logic [2:0]             eff_bytes;
    logic [LEN_FIELD_W-1:0] len_field;

    // Carry out of idx_inc marks the write that completes the block.
    assign idx_inc   = 5'(idx_q) + 5'd1;
    assign wr_base   = {4'd15 - idx_q, 5'd0};
    assign eff_bytes = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign len_field = LEN_FIELD_W'(len_q);
    assign blk_data  = buf_q;

    // Control, buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= FILL;
            idx_q     <= '0;
            len_q     <= '0;
            pend80_q  <= 1'b0;
            first_q   <= 1'b1;
            msg_end_q <= 1'b0;
            len_hi_q  <= 1'b0;
            buf_q     <= '0;
            in_ready  <= 1'b0;
            blk_valid <= 1'b0;
            blk_first <= 1'b0;
            blk_final <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        busy  <= 1'b1;
                        idx_q <= idx_inc[3:0];
                        if (in_last) begin
                            buf_q[wr_base +: WORD_W] <= last_word_mask(in_data, in_bytes);
                            len_q     <= len_q + LEN_W'({eff_bytes, 3'b000});
                            pend80_q  <= (eff_bytes == 3'd4);
                            msg_end_q <= 1'b1;
                            in_ready  <= 1'b0;
                            if (idx_inc[4]) begin
                                state_q   <= EMIT;
                                blk_valid <= 1'b1;
                                blk_first <= first_q;
                                blk_final <= 1'b0;
                            end else begin
                                state_q <= PAD;
                            end
                        end else begin
                            buf_q[wr_base +: WORD_W] <= in_data;
                            len_q <= len_q + LEN_W'(WORD_W);
                            if (idx_inc[4]) begin
                                state_q   <= EMIT;
                                in_ready  <= 1'b0;
                                blk_valid <= 1'b1;
                                blk_first <= first_q;
                                blk_final <= 1'b0;
                            end
                        end
                    end
                end

                // Zero words need no write: the buffer is cleared on every block handoff.
                PAD: begin
                    idx_q <= idx_inc[3:0];
                    if (pend80_q) begin
                        buf_q[wr_base +: WORD_W] <= PAD_WORD;
                        pend80_q <= 1'b0;
                    end else if (idx_q == 4'd14) begin
                        buf_q[wr_base +: WORD_W] <= len_field[LEN_FIELD_W-1 -: WORD_W];
                        len_hi_q <= 1'b1;
                    end else if (len_hi_q) begin
                        buf_q[wr_base +: WORD_W] <= len_field[WORD_W-1:0];
                    end
                    if (idx_inc[4]) begin
                        state_q   <= EMIT;
                        blk_valid <= 1'b1;
                        blk_first <= first_q;
                        blk_final <= len_hi_q;
                    end
                end

                EMIT: begin
                    if (blk_valid && blk_ready) begin
                        blk_valid <= 1'b0;
                        blk_first <= 1'b0;
                        blk_final <= 1'b0;
                        buf_q     <= '0;
                        idx_q     <= '0;
                        first_q   <= blk_final;
                        if (blk_final) begin
                            len_q     <= '0;
                            msg_end_q <= 1'b0;
                            len_hi_q  <= 1'b0;
                            state_q   <= FILL;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else if (msg_end_q) begin
                            state_q <= PAD;
                        end else begin
                            state_q  <= FILL;
                            in_ready <= 1'b1;
                        end
                    end
                end

                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Testbench for sha256_padder: directed and random messages checked against a byte-level
// padding model (message || 0x80 || zeros || 64-bit length, cut into 64-byte blocks).
module tb_sha256_padder;
    import sha256_padder_pkg::*;

    logic               clk;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               in_last;
    logic [2:0]         in_bytes;
    logic               blk_valid;
    logic               blk_ready;
    logic [511:0]       blk_data;
    logic               blk_first;
    logic               blk_final;
    logic               busy;

    sha256_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_final (blk_final),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ready_mode = 0;   // 0: hold off, 1: always ready, 2: random

    byte unsigned msg[$];
    logic [511:0] exp_blk[$];
    logic [511:0] got_data[$];
    logic         got_first[$];
    logic         got_final[$];

    // Consumer: drive blk_ready and record each block that will be taken at the next edge.
    always @(negedge clk) begin
        case (ready_mode)
            0:       blk_ready = 1'b0;
            1:       blk_ready = 1'b1;
            default: blk_ready = ($urandom_range(0, 2) != 0);
        endcase
        if (reset_n && blk_valid && blk_ready) begin
            got_data.push_back(blk_data);
            got_first.push_back(blk_first);
            got_final.push_back(blk_final);
        end
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference padding of the current message into expected blocks.
    task automatic build_expected();
        byte unsigned p[$];
        logic [63:0]  bl;
        logic [511:0] b;
        exp_blk.delete();
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) << 3;
        for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
        for (int k = 0; k < p.size() / 64; k++) begin
            for (int j = 0; j < 64; j++) b[511 - 8*j -: 8] = p[64*k + j];
            exp_blk.push_back(b);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word is accepted.
    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("in_ready_timeout", 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom();
    endtask

    task automatic send_msg(input int gap_max);
        int L = msg.size();
        int nw;
        int rem;
        logic [31:0] d;
        if (L == 0) begin
            send_word($urandom(), 1'b1, 3'd0);
        end else begin
            nw = (L + 3) / 4;
            for (int w = 0; w < nw; w++) begin
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
                d = $urandom();
                for (int b = 0; b < 4; b++)
                    if (4*w + b < L) d[31 - 8*b -: 8] = msg[4*w + b];
                rem = L - 4*w;
                if (w != nw - 1) send_word(d, 1'b0, 3'd0);
                else if (rem < 4) send_word(d, 1'b1, 3'(rem));
                else if ($urandom_range(0, 2) == 0) begin
                    send_word(d, 1'b0, 3'd0);
                    send_word($urandom(), 1'b1, 3'd0);
                end else send_word(d, 1'b1, 3'($urandom_range(4, 7)));
            end
        end
    endtask

    task automatic wait_blocks(input int n);
        int t = 0;
        while (got_data.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("block_count", 32'(got_data.size()), 32'(n));
    endtask

    task automatic compare_blocks(input string tag);
        int n = exp_blk.size();
        for (int i = 0; i < n && got_data.size() > 0; i++) begin
            check({tag, "_data"},  got_data.pop_front(),  exp_blk[i]);
            check({tag, "_first"}, got_first.pop_front(), (i == 0));
            check({tag, "_final"}, got_final.pop_front(), (i == n - 1));
        end
    endtask

    task automatic run_msg(input string tag, input int gap_max, input int mode);
        build_expected();
        ready_mode = mode;
        send_msg(gap_max);
        wait_blocks(exp_blk.size());
        compare_blocks(tag);
        repeat (3) @(negedge clk);
        check({tag, "_extra"}, 32'(got_data.size()), 32'd0);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [511:0] b0;
        int t;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = '0;
        ready_mode = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  in_ready,  1'b0);
        check("rst_blk_valid", blk_valid, 1'b0);
        check("rst_blk_first", blk_first, 1'b0);
        check("rst_blk_final", blk_final, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_blk_data",  blk_data,  512'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);

        // "abc" single block, with explicit word checks
        msg = '{8'h61, 8'h62, 8'h63};
        build_expected();
        ready_mode = 1;
        send_msg(0);
        wait_blocks(1);
        if (got_data.size() > 0) begin
            b0 = got_data[0];
            check("abc_w0",  b0[511:480], 32'h6162_6380);
            check("abc_w15", b0[31:0],    32'h0000_0018);
        end
        compare_blocks("abc");
        repeat (3) @(negedge clk);

        // Empty message
        msg.delete();
        run_msg("empty", 0, 1);

        // 56 bytes: terminator lands at idx 14, length spills into a second block
        msg.delete();
        for (int i = 0; i < 56; i++) msg.push_back(8'(i + 1));
        run_msg("len56", 0, 1);

        // 52 bytes: terminator at idx 13, still a single block
        msg.delete();
        for (int i = 0; i < 52; i++) msg.push_back(8'(255 - i));
        run_msg("len52", 0, 1);

        // Consumer stalls in EMIT; stray in_valid must be ignored
        msg = '{8'h61, 8'h62, 8'h63};
        build_expected();
        ready_mode = 0;
        send_msg(0);
        t = 0;
        while (!blk_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("hold_valid_seen", blk_valid, 1'b1);
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_bytes = 3'd2;
        in_data  = 32'hdead_beef;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold_data",     blk_data,  exp_blk[0]);
            check("hold_first",    blk_first, 1'b1);
            check("hold_final",    blk_final, 1'b1);
            check("hold_valid",    blk_valid, 1'b1);
            check("hold_in_ready", in_ready,  1'b0);
            check("hold_busy",     busy,      1'b1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        ready_mode = 1;
        wait_blocks(1);
        compare_blocks("hold");
        repeat (3) @(negedge clk);
        check("hold_extra", 32'(got_data.size()), 32'd0);

        // Reset in the middle of a message discards it
        ready_mode = 1;
        for (int w = 0; w < 5; w++) send_word($urandom(), 1'b0, 3'd0);
        check("mid_busy", busy, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", blk_valid, 1'b0);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0 || c == 19) check("mid_after_valid", blk_valid, 1'b0);
        end
        check("mid_no_block", 32'(got_data.size()), 32'd0);
        check("mid_busy_clear", busy, 1'b0);
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg("abc_again", 0, 1);

        // Random messages with random gaps and consumer back-pressure
        for (int m = 0; m < 30; m++) begin
            int len;
            case (m % 6)
                0:       len = 55 + 64 * $urandom_range(0, 1);
                1:       len = 56 + 64 * $urandom_range(0, 1);
                2:       len = 64 * $urandom_range(1, 2);
                default: len = $urandom_range(0, 150);
            endcase
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom()));
            run_msg($sformatf("rnd%0d_len%0d", m, len), 2, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
